// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter for the shared L2 request port. Sequences one transaction at a time,
// with an invalidate snoop and ack collection ahead of every write.
module l2_bus_arbiter #(
   parameter int unsigned NUM_CORES  = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_CORES-1:0]            c_req_valid,
   input  logic [NUM_CORES-1:0]            c_req_wr,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] c_req_addr,
   input  logic [NUM_CORES*DATA_WIDTH-1:0] c_req_wdata,
   output logic [NUM_CORES-1:0]            c_resp_valid,
   output logic [DATA_WIDTH-1:0]           c_resp_rdata,
   output logic                            snoop_valid,
   output logic [ADDR_WIDTH-1:0]           snoop_addr,
   output logic [1:0]                      snoop_source_id,
   input  logic [NUM_CORES-1:0]            snoop_ack,
   output logic                            l2_req_valid,
   output logic                            l2_req_wr,
   output logic [ADDR_WIDTH-1:0]           l2_req_addr,
   output logic [DATA_WIDTH-1:0]           l2_req_wdata,
   input  logic                            l2_resp_valid,
   input  logic [DATA_WIDTH-1:0]           l2_resp_rdata,
   output logic [1:0]                      grant_id,
   output logic                            bus_busy,
   output logic                            timeout_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, SNOOP, SNOOP_WAIT, L2_ISSUE, L2_WAIT, RESP
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             last_q, last_d;
   logic [1:0]             gid_q, gid_d;
   logic                   wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [NUM_CORES-1:0]   ack_q, ack_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_CORES-1:0]   resp_vld_q, resp_vld_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   snoop_vld_q, snoop_vld_d;
   logic [ADDR_WIDTH-1:0]  snoop_addr_q, snoop_addr_d;
   logic [1:0]             snoop_src_q, snoop_src_d;
   logic                   l2_vld_q, l2_vld_d;
   logic                   l2_wr_q, l2_wr_d;
   logic [ADDR_WIDTH-1:0]  l2_addr_q, l2_addr_d;
   logic [DATA_WIDTH-1:0]  l2_wdata_q, l2_wdata_d;
   logic                   busy_q, busy_d;
   logic                   terr_q, terr_d;

   logic                   sel_found;
   logic [1:0]             sel_id;
   logic                   sel_wr;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic [NUM_CORES-1:0]   ack_all;

   // Round-robin pick: scanning offsets high to low lets the nearest requester after last_q win.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = int'(NUM_CORES); k >= 1; k--) begin
         for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (c_req_valid[i] && (((int'(last_q) + k) % int'(NUM_CORES)) == i)) begin
               sel_found = 1'b1;
               sel_id    = 2'(i);
               sel_wr    = c_req_wr[i];
               sel_addr  = c_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               sel_wdata = c_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      gid_d        = gid_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ack_d        = ack_q;
      cnt_d        = cnt_q;
      resp_vld_d   = '0;
      rdata_d      = rdata_q;
      snoop_vld_d  = 1'b0;
      snoop_addr_d = snoop_addr_q;
      snoop_src_d  = snoop_src_q;
      l2_vld_d     = 1'b0;
      l2_wr_d      = l2_wr_q;
      l2_addr_d    = l2_addr_q;
      l2_wdata_d   = l2_wdata_q;
      terr_d       = terr_q;
      ack_all      = ack_q | snoop_ack;

      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               gid_d   = sel_id;
               last_d  = sel_id;
               wr_d    = sel_wr;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               if (sel_wr) begin
                  state_d      = SNOOP;
                  snoop_vld_d  = 1'b1;
                  snoop_addr_d = sel_addr;
                  snoop_src_d  = sel_id;
               end else begin
                  state_d    = L2_ISSUE;
                  l2_vld_d   = 1'b1;
                  l2_wr_d    = 1'b0;
                  l2_addr_d  = sel_addr;
                  l2_wdata_d = sel_wdata;
               end
            end
         end
         SNOOP: begin
            ack_d   = NUM_CORES'(1) << gid_q;
            cnt_d   = '0;
            state_d = SNOOP_WAIT;
         end
         SNOOP_WAIT: begin
            ack_d = ack_all;
            if ((&ack_all) || (cnt_q == CNT_LAST)) begin
               if (!(&ack_all)) begin
                  terr_d = 1'b1;
               end
               state_d    = L2_ISSUE;
               l2_vld_d   = 1'b1;
               l2_wr_d    = wr_q;
               l2_addr_d  = addr_q;
               l2_wdata_d = wdata_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         L2_ISSUE: begin
            cnt_d   = '0;
            state_d = L2_WAIT;
         end
         L2_WAIT: begin
            if (l2_resp_valid) begin
               rdata_d    = l2_resp_rdata;
               resp_vld_d = NUM_CORES'(1) << gid_q;
               state_d    = RESP;
            end else if (cnt_q == CNT_LAST) begin
               terr_d     = 1'b1;
               rdata_d    = '0;
               resp_vld_d = NUM_CORES'(1) << gid_q;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= 2'(NUM_CORES - 1);
         gid_q        <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ack_q        <= '0;
         cnt_q        <= '0;
         resp_vld_q   <= '0;
         rdata_q      <= '0;
         snoop_vld_q  <= 1'b0;
         snoop_addr_q <= '0;
         snoop_src_q  <= '0;
         l2_vld_q     <= 1'b0;
         l2_wr_q      <= 1'b0;
         l2_addr_q    <= '0;
         l2_wdata_q   <= '0;
         busy_q       <= 1'b0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         gid_q        <= gid_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ack_q        <= ack_d;
         cnt_q        <= cnt_d;
         resp_vld_q   <= resp_vld_d;
         rdata_q      <= rdata_d;
         snoop_vld_q  <= snoop_vld_d;
         snoop_addr_q <= snoop_addr_d;
         snoop_src_q  <= snoop_src_d;
         l2_vld_q     <= l2_vld_d;
         l2_wr_q      <= l2_wr_d;
         l2_addr_q    <= l2_addr_d;
         l2_wdata_q   <= l2_wdata_d;
         busy_q       <= busy_d;
         terr_q       <= terr_d;
      end
   end

   assign c_resp_valid    = resp_vld_q;
   assign c_resp_rdata    = rdata_q;
   assign snoop_valid     = snoop_vld_q;
   assign snoop_addr      = snoop_addr_q;
   assign snoop_source_id = snoop_src_q;
   assign l2_req_valid    = l2_vld_q;
   assign l2_req_wr       = l2_wr_q;
   assign l2_req_addr     = l2_addr_q;
   assign l2_req_wdata    = l2_wdata_q;
   assign grant_id        = gid_q;
   assign bus_busy        = busy_q;
   assign timeout_err     = terr_q;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: L2 memory and snoop-ack responders plus a transaction-order
// reference model that predicts grant order and response data for each phase.
module tb_l2_bus_arbiter;

   localparam int NC = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 64;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NC-1:0]      c_req_valid = '0;
   logic [NC-1:0]      c_req_wr = '0;
   logic [NC*AW-1:0]   c_req_addr = '0;
   logic [NC*DW-1:0]   c_req_wdata = '0;
   logic [NC-1:0]      c_resp_valid;
   logic [DW-1:0]      c_resp_rdata;
   logic               snoop_valid;
   logic [AW-1:0]      snoop_addr;
   logic [1:0]         snoop_source_id;
   logic [NC-1:0]      snoop_ack = '0;
   logic               l2_req_valid;
   logic               l2_req_wr;
   logic [AW-1:0]      l2_req_addr;
   logic [DW-1:0]      l2_req_wdata;
   logic               l2_resp_valid = 1'b0;
   logic [DW-1:0]      l2_resp_rdata = '0;
   logic [1:0]         grant_id;
   logic               bus_busy;
   logic               timeout_err;

   l2_bus_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req_valid(c_req_valid), .c_req_wr(c_req_wr), .c_req_addr(c_req_addr),
      .c_req_wdata(c_req_wdata), .c_resp_valid(c_resp_valid), .c_resp_rdata(c_resp_rdata),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_source_id(snoop_source_id),
      .snoop_ack(snoop_ack), .l2_req_valid(l2_req_valid), .l2_req_wr(l2_req_wr),
      .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata), .l2_resp_valid(l2_resp_valid),
      .l2_resp_rdata(l2_resp_rdata), .grant_id(grant_id), .bus_busy(bus_busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // Stimulus tables and bench-side state.
   txn_t          tx[NC][16];
   int            ntx[NC];
   int            ptr[NC];
   logic [DW-1:0] l2mem[int];
   logic [DW-1:0] ref_mem[int];
   int            ref_last = NC - 1;
   bit            l2_en = 1'b1;
   logic [NC-1:0] ack_en = '1;
   int            obs_core[$];
   logic [DW-1:0] obs_data[$];
   int            exp_core[$];
   logic [DW-1:0] exp_data[$];

   bit            l2_pend = 1'b0;
   logic [DW-1:0] l2_pdata = '0;
   bit            ack_pend = 1'b0;
   int            l2_pulses = 0;
   int            l2_cyc = 0;
   logic          last_l2_wr = 1'b0;
   logic [AW-1:0] last_l2_addr = '0;
   int            snoop_pulses = 0;
   int            snoop_cyc = 0;
   logic [AW-1:0] last_snoop_addr = '0;
   logic [1:0]    last_snoop_src = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_core(input int c);
      txn_t t;
      t = tx[c][ptr[c]];
      c_req_valid[c]          = 1'b1;
      c_req_wr[c]             = t.wr;
      c_req_addr[c*AW +: AW]  = t.addr;
      c_req_wdata[c*DW +: DW] = t.wdata;
   endtask

   task automatic add_txn(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      tx[c][ntx[c]] = '{wr: wr, addr: a, wdata: d};
      ntx[c]++;
   endtask

   task automatic clear_txns();
      for (int c = 0; c < NC; c++) begin
         ntx[c] = 0;
         ptr[c] = 0;
      end
   endtask

   // L2 memory, snoop-ack responders, response log and per-core request sequencing.
   always @(negedge clk) begin
      if (!rst_n) begin
         l2_pend       = 1'b0;
         l2_resp_valid = 1'b0;
         ack_pend      = 1'b0;
         snoop_ack     = '0;
      end else begin
         l2_resp_valid = 1'b0;
         if (l2_pend) begin
            l2_pend       = 1'b0;
            l2_resp_valid = 1'b1;
            l2_resp_rdata = l2_pdata;
         end
         if (l2_req_valid) begin
            l2_pulses++;
            l2_cyc       = cyc;
            last_l2_wr   = l2_req_wr;
            last_l2_addr = l2_req_addr;
            if (l2_en) begin
               l2_pend = 1'b1;
               if (l2_req_wr) begin
                  l2mem[int'(l2_req_addr >> 2)] = l2_req_wdata;
                  l2_pdata = '0;
               end else begin
                  l2_pdata = l2mem.exists(int'(l2_req_addr >> 2)) ? l2mem[int'(l2_req_addr >> 2)] : '0;
               end
            end
         end
         snoop_ack = '0;
         if (ack_pend) begin
            snoop_ack = ack_en;
            ack_pend  = 1'b0;
         end
         if (snoop_valid) begin
            snoop_pulses++;
            snoop_cyc       = cyc;
            last_snoop_addr = snoop_addr;
            last_snoop_src  = snoop_source_id;
            ack_pend        = 1'b1;
         end
         if (c_resp_valid != '0) begin
            int rc;
            rc = 0;
            check("resp_onehot", 64'($onehot(c_resp_valid)), 64'd1);
            for (int c = 0; c < NC; c++) if (c_resp_valid[c]) rc = c;
            obs_core.push_back(rc);
            obs_data.push_back(c_resp_rdata);
            ptr[rc]++;
            if (ptr[rc] < ntx[rc]) drive_core(rc);
            else c_req_valid[rc] = 1'b0;
         end
      end
   end

   // Reference model: each grant goes to the next core after the previous grantee that still has
   // work; reads return memory contents, writes return 0, a silent L2 returns 0.
   task automatic build_expect();
      int p[NC];
      int total;
      int last;
      txn_t t;
      total = 0;
      for (int c = 0; c < NC; c++) begin
         p[c] = 0;
         total += ntx[c];
      end
      last = ref_last;
      exp_core.delete();
      exp_data.delete();
      for (int n = 0; n < total; n++) begin
         int pick;
         int key;
         pick = -1;
         for (int k = NC; k >= 1; k--) begin
            int c;
            c = (last + k) % NC;
            if (p[c] < ntx[c]) pick = c;
         end
         t = tx[pick][p[pick]];
         p[pick]++;
         last = pick;
         key = int'(t.addr >> 2);
         exp_core.push_back(pick);
         if (!l2_en) exp_data.push_back('0);
         else if (t.wr) begin
            ref_mem[key] = t.wdata;
            exp_data.push_back('0);
         end else exp_data.push_back(ref_mem.exists(key) ? ref_mem[key] : '0);
      end
      ref_last = last;
   endtask

   task automatic run_phase(input string name, input int budget);
      build_expect();
      obs_core.delete();
      obs_data.delete();
      for (int c = 0; c < NC; c++) ptr[c] = 0;
      @(negedge clk);
      #1;
      for (int c = 0; c < NC; c++) if (ntx[c] > 0) drive_core(c);
      for (int i = 0; i < budget && obs_core.size() < exp_core.size(); i++) @(posedge clk);
      #1;
      check({name, "_count"}, 64'(obs_core.size()), 64'(exp_core.size()));
      for (int n = 0; n < exp_core.size() && n < obs_core.size(); n++) begin
         check($sformatf("%s_core%0d", name, n), 64'(obs_core[n]), 64'(exp_core[n]));
         check($sformatf("%s_data%0d", name, n), 64'(obs_data[n]), 64'(exp_data[n]));
      end
      repeat (3) @(posedge clk);
      #1;
      check({name, "_idle"}, 64'(bus_busy), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      c_req_valid = '0;
      clear_txns();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ref_last = NC - 1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_resp_valid"}, 64'(c_resp_valid), 64'd0);
      check({name, "_resp_rdata"}, 64'(c_resp_rdata), 64'd0);
      check({name, "_snoop_valid"}, 64'(snoop_valid), 64'd0);
      check({name, "_snoop_addr"}, 64'(snoop_addr), 64'd0);
      check({name, "_l2_valid"}, 64'(l2_req_valid), 64'd0);
      check({name, "_l2_addr"}, 64'(l2_req_addr), 64'd0);
      check({name, "_grant_id"}, 64'(grant_id), 64'd0);
      check({name, "_busy"}, 64'(bus_busy), 64'd0);
      check({name, "_terr"}, 64'(timeout_err), 64'd0);
   endtask

   initial begin
      int base_l2;
      int base_snoop;
      int gap;
      clear_txns();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Core0 read of a preloaded word.
      l2mem[32'h10] = 32'h1234;
      ref_mem[32'h10] = 32'h1234;
      clear_txns();
      add_txn(0, 1'b0, 32'h40, '0);
      base_l2 = l2_pulses;
      run_phase("t1", 50);
      check("t1_l2_pulses", 64'(l2_pulses - base_l2), 64'd1);
      check("t1_l2_addr", 64'(last_l2_addr), 64'h40);

      // Both cores read, twice each, always contending.
      l2mem[32'h11] = 32'h5555;
      ref_mem[32'h11] = 32'h5555;
      clear_txns();
      add_txn(0, 1'b0, 32'h40, '0);
      add_txn(0, 1'b0, 32'h44, '0);
      add_txn(1, 1'b0, 32'h44, '0);
      add_txn(1, 1'b0, 32'h40, '0);
      base_l2 = l2_pulses;
      run_phase("t2", 100);
      check("t2_l2_pulses", 64'(l2_pulses - base_l2), 64'd4);

      // Core1 write; only core0 acks, the source's own bit must be implied.
      ack_en = 2'b01;
      clear_txns();
      add_txn(1, 1'b1, 32'h80, 32'hA5A5);
      base_snoop = snoop_pulses;
      run_phase("t3", 100);
      check("t3_snoops", 64'(snoop_pulses - base_snoop), 64'd1);
      check("t3_snoop_addr", 64'(last_snoop_addr), 64'h80);
      check("t3_snoop_src", 64'(last_snoop_src), 64'd1);
      check("t3_l2_wr", 64'(last_l2_wr), 64'd1);
      check("t3_mem", 64'(l2mem.exists(32'h20) ? l2mem[32'h20] : 32'hDEAD_BEEF), 64'hA5A5);
      check("t3_fast", 64'((l2_cyc - snoop_cyc) < 5), 64'd1);
      check("t3_terr", 64'(timeout_err), 64'd0);

      // Random mixed reads/writes from both cores.
      ack_en = 2'b11;
      clear_txns();
      for (int c = 0; c < NC; c++) begin
         for (int n = 0; n < 6; n++) begin
            add_txn(c, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, 32'($urandom));
         end
      end
      run_phase("rnd", 400);
      check("rnd_terr", 64'(timeout_err), 64'd0);

      // Core0 write with core1 never acking.
      ack_en = 2'b01;
      clear_txns();
      add_txn(0, 1'b1, 32'h100, 32'hBEEF);
      base_l2 = l2_pulses;
      run_phase("t4", 300);
      gap = l2_cyc - snoop_cyc;
      check("t4_terr", 64'(timeout_err), 64'd1);
      check("t4_l2_pulses", 64'(l2_pulses - base_l2), 64'd1);
      check("t4_l2_wr", 64'(last_l2_wr), 64'd1);
      check("t4_gap", 64'(gap >= TO && gap <= TO + 2), 64'd1);
      ack_en = 2'b11;

      // Silent L2 on a core0 read, then a normal request.
      do_reset();
      #1;
      check("t5_terr_clear", 64'(timeout_err), 64'd0);
      l2_en = 1'b0;
      clear_txns();
      add_txn(0, 1'b0, 32'h40, '0);
      run_phase("t5", 300);
      check("t5_terr", 64'(timeout_err), 64'd1);
      l2_en = 1'b1;
      clear_txns();
      add_txn(1, 1'b0, 32'h44, '0);
      run_phase("t5b", 50);

      // Reset while waiting on L2: no response, then core0 wins a tie.
      l2_en = 1'b0;
      clear_txns();
      add_txn(0, 1'b0, 32'h40, '0);
      obs_core.delete();
      obs_data.delete();
      base_l2 = l2_pulses;
      @(negedge clk);
      #1;
      drive_core(0);
      for (int i = 0; i < 20 && l2_pulses == base_l2; i++) @(posedge clk);
      check("t6_issued", 64'(l2_pulses - base_l2), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("t6_busy", 64'(bus_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("t6");
      c_req_valid = '0;
      clear_txns();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ref_last = NC - 1;
      repeat (TO + 10) @(posedge clk);
      #1;
      check("t6_no_resp", 64'(obs_core.size()), 64'd0);
      l2_en = 1'b1;
      clear_txns();
      add_txn(0, 1'b0, 32'h44, '0);
      add_txn(1, 1'b0, 32'h40, '0);
      run_phase("t6b", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
